// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction per memory instruction, with
// alignment check, bus timeout and sign/zero extension of load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  mem_wr_en_i,
  input  logic [3:0]            byte_en_i,
  input  logic                  signed_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wr_data_i,
  output logic                  stall_o,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  load_store_unit_if.master     bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       strb_q;
  logic [31:0]      wdata_q;
  logic [3:0]       size_q;
  logic             sgn_q;
  logic [1:0]       off_q;

  logic size_byte, size_half, size_word, legal, aligned, accept, reject;

  always_comb begin
    size_byte = (byte_en_i == 4'b0001);
    size_half = (byte_en_i == 4'b0011);
    size_word = (byte_en_i == 4'b1111);
    legal     = size_byte | size_half | size_word;
    aligned   = size_byte | (size_half & ~addr_i[0]) | (size_word & (addr_i[1:0] == 2'b00));
    accept    = (state == IDLE) & req_i & legal & aligned;
    reject    = (state == IDLE) & req_i & legal & ~aligned;
    stall_o   = accept | (state == BUSY);
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wstrb_o = strb_q;
  assign bus.bus_wdata_o = wdata_q;

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [3:0]  size,
                                              input logic        sgn);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      4'b0001: format_load = {{24{sgn & shifted[7]}}, shifted[7:0]};
      4'b0011: format_load = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: format_load = shifted;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      busy_cnt     <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      strb_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      off_q        <= '0;
      rd_data_o    <= '0;
      rd_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rd_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            busy_cnt <= '0;
            req_q    <= 1'b1;
            we_q     <= mem_wr_en_i;
            addr_q   <= {addr_i[31:2], 2'b00};
            strb_q   <= byte_en_i << addr_i[1:0];
            wdata_q  <= wr_data_i << {addr_i[1:0], 3'b000};
            size_q   <= byte_en_i;
            sgn_q    <= signed_i;
            off_q    <= addr_i[1:0];
          end else if (reject) begin
            misaligned_o <= 1'b1;
          end
        end
        BUSY: begin
          // Ack is tested first so an ack on the final cycle wins over timeout.
          if (bus.bus_ack_i) begin
            req_q    <= 1'b0;
            busy_cnt <= '0;
            if (we_q) begin
              state <= IDLE;
            end else begin
              rd_data_o  <= format_load(bus.bus_rdata_i, off_q, size_q, sgn_q);
              rd_valid_o <= 1'b1;
              state      <= DONE;
            end
          end else if (busy_cnt == CNT_LAST) begin
            req_q    <= 1'b0;
            busy_cnt <= '0;
            err_o    <= 1'b1;
            state    <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected load results are queued at
// issue and popped when rd_valid_o is seen.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'b0000;
  logic        sgn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        misaligned;
  logic        err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .mem_wr_en_i  (we),
    .byte_en_i    (be),
    .signed_i     (sgn),
    .addr_i       (addr),
    .wr_data_i    (wdata),
    .stall_o      (stall),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .misaligned_o (misaligned),
    .err_o        (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] t_addr [6] = '{32'h7000, 32'h7001, 32'h7002, 32'h7003, 32'h7000, 32'h7002};
  logic [3:0]  t_be   [6] = '{4'b1111, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
  logic        t_sgn  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] t_rdat [6] = '{32'hDEADBEEF, 32'h00007F00, 32'h80010000,
                              32'hF0000000, 32'h00007FFF, 32'h00FF0000};
  int unsigned t_dly  [6] = '{0, 1, 2, 0, 1, 0};

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] o,
                                             input logic [3:0] b, input logic s);
    logic [7:0]  by;
    logic [15:0] hw;
    by = w[8*o +: 8];
    hw = o[1] ? w[31:16] : w[15:0];
    case (b)
      4'b0001: return s ? {{24{by[7]}}, by} : {24'h0, by};
      4'b0011: return s ? {{16{hw[15]}}, hw} : {16'h0, hw};
      default: return w;
    endcase
  endfunction

  task automatic drive_req(input logic w, input logic [3:0] b, input logic s,
                           input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; sgn = s; addr = a; wdata = d;
  endtask

  task automatic test_reset;
    bus.bus_ack_i = 1'b0;
    bus.bus_rdata_i = '0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({stall, rd_data, rd_valid, misaligned, err, bus.bus_req_o, bus.bus_we_o,
         bus.bus_addr_o, bus.bus_wstrb_o, bus.bus_wdata_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got stall=%b rd=%h v=%b mis=%b err=%b req=%b we=%b a=%h s=%b d=%h required all 0",
               stall, rd_data, rd_valid, misaligned, err, bus.bus_req_o, bus.bus_we_o,
               bus.bus_addr_o, bus.bus_wstrb_o, bus.bus_wdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_lb_sign;
    @(negedge clk);
    drive_req(1'b0, 4'b0001, 1'b1, 32'h0000_1003, '0);
    sb_q.push_back(32'hFFFF_FF80);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall_accept: got %b required 1", stall); end
    @(negedge clk);
    req = 1'b0;
    n_cmp++;
    if ({bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o} !== {1'b1, 1'b0, 32'h1000, 4'b1000}) begin
      n_bad++;
      $display("FAIL lb_bus: got req=%b we=%b addr=%h strb=%b required 1 0 00001000 1000",
               bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o);
    end
    bus.bus_ack_i = 1'b1;
    bus.bus_rdata_i = 32'h80FF_FFFF;
    @(negedge clk);
    bus.bus_ack_i = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL lb_latency: rd_valid got %b required 1", rd_valid); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (rd_data !== exp_v) begin n_bad++; $display("FAIL lb_data: got %h required %h", rd_data, exp_v); end
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_stall_done: got %b required 0", stall); end
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL lb_valid_pulse: got %b required 0", rd_valid); end
  endtask

  task automatic test_lhu;
    drive_req(1'b0, 4'b0011, 1'b0, 32'h0000_2002, '0);
    sb_q.push_back(32'h0000_BEEF);
    @(negedge clk);
    req = 1'b0;
    n_cmp++;
    if ({bus.bus_addr_o, bus.bus_wstrb_o} !== {32'h2000, 4'b1100}) begin
      n_bad++;
      $display("FAIL lhu_bus: got addr=%h strb=%b required 00002000 1100", bus.bus_addr_o, bus.bus_wstrb_o);
    end
    bus.bus_ack_i = 1'b1;
    bus.bus_rdata_i = 32'hBEEF_1234;
    @(negedge clk);
    bus.bus_ack_i = 1'b0;
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_bad++;
      $display("FAIL lhu_data: got v=%b %h required v=1 %h", rd_valid, rd_data, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_sb_delayed;
    logic bad;
    bad = 1'b0;
    drive_req(1'b1, 4'b0001, 1'b0, 32'h0000_3001, 32'h0000_00AB);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_accept: got %b required 1", stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (bus.bus_req_o !== 1'b1 || bus.bus_we_o !== 1'b1 || bus.bus_addr_o !== 32'h3000 ||
          bus.bus_wstrb_o !== 4'b0010 || bus.bus_wdata_o !== 32'h0000_AB00 || stall !== 1'b1) begin
        bad = 1'b1;
        $display("busy cycle %0d: req=%b we=%b addr=%h strb=%b wdata=%h stall=%b", i,
                 bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o, bus.bus_wdata_o, stall);
      end
      if (i == 2) bus.bus_ack_i = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin n_bad++; $display("FAIL sb_busy_hold: got unstable=%b required 0", bad); end
    @(negedge clk);
    bus.bus_ack_i = 1'b0;
    n_cmp++;
    if ({stall, bus.bus_req_o, rd_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL sb_after_ack: got stall=%b req=%b v=%b required 0 0 0", stall, bus.bus_req_o, rd_valid);
    end
  endtask

  task automatic test_misaligned;
    logic seen_stall;
    @(negedge clk);
    drive_req(1'b0, 4'b1111, 1'b0, 32'h0000_4002, '0);
    #1;
    seen_stall = stall;
    @(negedge clk);
    req = 1'b0;
    n_cmp++;
    if ({misaligned, bus.bus_req_o, stall, seen_stall} !== 4'b1000) begin
      n_bad++;
      $display("FAIL misaligned_pulse: got mis=%b req=%b stall=%b stall_req=%b required 1 0 0 0",
               misaligned, bus.bus_req_o, stall, seen_stall);
    end
    @(negedge clk);
    n_cmp++;
    if ({misaligned, bus.bus_req_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL misaligned_once: got mis=%b req=%b required 0 0", misaligned, bus.bus_req_o);
    end
  endtask

  task automatic test_timeout;
    logic bad;
    bad = 1'b0;
    drive_req(1'b0, 4'b1111, 1'b0, 32'h0000_5000, '0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (bus.bus_req_o !== 1'b1 || err !== 1'b0 || rd_valid !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got early_exit=%b required 0", bad); end
    @(negedge clk);
    n_cmp++;
    if ({err, bus.bus_req_o, rd_valid, stall} !== 4'b1000) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%b req=%b v=%b stall=%b required 1 0 0 0",
               err, bus.bus_req_o, rd_valid, stall);
    end
    @(negedge clk);
    n_cmp++;
    if ({err, rd_valid} !== 2'b00) begin n_bad++; $display("FAIL timeout_err_once: got err=%b v=%b required 0 0", err, rd_valid); end

    drive_req(1'b0, 4'b1111, 1'b0, 32'h0000_5004, '0);
    sb_q.push_back(32'hCAFE_F00D);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (i == 16) begin
        bus.bus_ack_i = 1'b1;
        bus.bus_rdata_i = 32'hCAFE_F00D;
      end
    end
    @(negedge clk);
    bus.bus_ack_i = 1'b0;
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (err !== 1'b0 || rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_bad++;
      $display("FAIL timeout_last_ack: got err=%b v=%b %h required err=0 v=1 %h", err, rd_valid, rd_data, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      drive_req(1'b0, t_be[n], t_sgn[n], t_addr[n], '0);
      sb_q.push_back(model_load(t_rdat[n], t_addr[n][1:0], t_be[n], t_sgn[n]));
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d]: stall got %b required 1", n, stall); end
      @(negedge clk);
      req = 1'b0;
      for (int d = 0; d < int'(t_dly[n]); d++) @(negedge clk);
      bus.bus_ack_i = 1'b1;
      bus.bus_rdata_i = t_rdat[n];
      @(negedge clk);
      bus.bus_ack_i = 1'b0;
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_data[%0d]: got v=%b %h required v=1 %h", n, rd_valid, rd_data, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_busy;
    drive_req(1'b1, 4'b1111, 1'b0, 32'h0000_6000, 32'h5555_AAAA);
    @(negedge clk);
    req = 1'b0;
    n_cmp++;
    if (bus.bus_req_o !== 1'b1) begin n_bad++; $display("FAIL rst_busy_req: got %b required 1", bus.bus_req_o); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.bus_req_o, stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_async_drop: got req=%b stall=%b required 0 0", bus.bus_req_o, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 4'b1111, 1'b0, 32'h0000_0000, '0);
    sb_q.push_back(32'h1234_5678);
    @(negedge clk);
    req = 1'b0;
    bus.bus_ack_i = 1'b1;
    bus.bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.bus_ack_i = 1'b0;
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      n_bad++;
      $display("FAIL rst_then_lw: got v=%b %h required v=1 %h", rd_valid, rd_data, exp_v);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu();
    test_sb_delayed();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
